// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD centisecond stopwatch core with start/stop/clear/lap control
//
// Purpose: counts centiseconds in BCD (00.00 .. SEC_WRAP-0.01) on each rising edge of the
// divider time-base while running, and shows either the live count or a frozen lap snapshot.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   tick_in     10 ms time-base level; each rising edge is one centisecond
//   start_stop  command pulse: IDLE->RUN, RUN->PAUSED, PAUSED->RUN
//   clear       command pulse: zero everything from IDLE or PAUSED (ignored in RUN)
//   lap         command pulse: take/release a lap snapshot
//   disp_bcd    {tens s, s, tenths, hundredths}
//   running     high in RUN
//   lap_active  display frozen on the lap snapshot
//   wrap        one-cycle pulse, coincident with the count reading 00.00 after rollover
module stopwatch_core #(
  parameter int SEC_WRAP = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  localparam logic [3:0] TENS_MAX = 4'(SEC_WRAP / 10 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] lap_q, lap_d;
  logic        lap_active_q, lap_active_d;
  logic        wrap_q, wrap_d;
  logic        tick_q;
  logic        tick_rise;
  logic [15:0] count_inc;
  logic        roll;

  assign tick_rise = tick_in & ~tick_q;

  // Ripple BCD increment; roll flags the return to 00.00.
  always_comb begin
    count_inc = count_q;
    roll      = 1'b0;
    if (count_q[3:0] < 4'd9) begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] < 4'd9) begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] < 4'd9) begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count_q[15:12] < TENS_MAX) begin
            count_inc[15:12] = count_q[15:12] + 4'd1;
          end else begin
            count_inc[15:12] = 4'd0;
            roll             = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    wrap_d       = 1'b0;

    // Counting depends only on the pre-edge state, so a start_stop that pauses
    // still lets the coincident tick through, and one that starts does not.
    if (state_q == RUN && tick_rise) begin
      count_d = count_inc;
      wrap_d  = roll;
    end

    // One command per cycle: clear wins even when it is itself ignored in RUN.
    if (clear) begin
      if (state_q != RUN) begin
        state_d      = IDLE;
        count_d      = 16'h0000;
        lap_d        = 16'h0000;
        lap_active_d = 1'b0;
      end
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSED;
        PAUSED:  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (state_q == RUN) begin
        lap_d        = count_q;
        lap_active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 16'h0000;
      lap_q        <= 16'h0000;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
      tick_q       <= tick_in;
    end
  end

  assign disp_bcd   = lap_active_q ? lap_q : count_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core
module tb_stopwatch_core;

  logic        clk;
  logic        reset;
  logic        tick_in;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        wrap;

  stopwatch_core #(.SEC_WRAP(60)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        cl;
    logic        lp;
    logic        tk;
    logic [15:0] bcd;
    logic        run;
    logic        lapa;
    logic        wrp;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        run;
    logic        lapa;
    logic        wrp;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];
  exp_t  e_cur;
  string nm_cur;
  int    checks = 0;
  int    errors = 0;

  // Reference model: plain centisecond integers, state 0=idle 1=run 2=paused.
  int   m_cs;
  int   m_lap;
  logic m_lapa;
  int   m_st;

  vec_t tbl [26];

  // Scoreboard consumer: each entry describes the outputs after the next edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e_cur  = sb.pop_front();
      nm_cur = sb_nm.pop_front();
      checks = checks + 1;
      if ({disp_bcd, running, lap_active, wrap} !== {e_cur.bcd, e_cur.run, e_cur.lapa, e_cur.wrp}) begin
        errors = errors + 1;
        $display("FAIL %s: got bcd=%h run=%b lap=%b wrap=%b, expected bcd=%h run=%b lap=%b wrap=%b",
                 nm_cur, disp_bcd, running, lap_active, wrap, e_cur.bcd, e_cur.run, e_cur.lapa, e_cur.wrp);
      end
    end
  end

  function automatic logic [15:0] bcd_of(input int cs);
    logic [15:0] r;
    r[15:12] = 4'(cs / 1000);
    r[11:8]  = 4'((cs / 100) % 10);
    r[7:4]   = 4'((cs / 10) % 10);
    r[3:0]   = 4'(cs % 10);
    return r;
  endfunction

  function automatic logic [15:0] disp_exp();
    return m_lapa ? bcd_of(m_lap) : bcd_of(m_cs);
  endfunction

  task automatic push(input logic [15:0] b, input logic r, input logic la, input logic w, input string nm);
    exp_t e;
    e.bcd  = b;
    e.run  = r;
    e.lapa = la;
    e.wrp  = w;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic drive(input logic ss, input logic cl, input logic lp, input logic tk, input logic chk,
                       input logic [15:0] b, input logic r, input logic la, input logic w, input string nm);
    @(posedge clk);
    #2;
    reset      = 1'b0;
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    tick_in    = tk;
    if (chk) push(b, r, la, w, nm);
  endtask

  task automatic do_reset(input logic ss, input logic lp, input logic tk);
    @(posedge clk);
    #2;
    reset      = 1'b1;
    start_stop = ss;
    clear      = 1'b0;
    lap        = lp;
    tick_in    = tk;
    push(16'h0000, 1'b0, 1'b0, 1'b0, "reset_state");
    m_st   = 0;
    m_cs   = 0;
    m_lap  = 0;
    m_lapa = 1'b0;
  endtask

  task automatic tick_pulse(input logic chk);
    logic w;
    w = 1'b0;
    if (m_st == 1) begin
      m_cs = (m_cs + 1) % 6000;
      w    = (m_cs == 0);
    end
    drive(0, 0, 0, 1, chk, disp_exp(), m_st == 1, m_lapa, w, "tick_edge");
    drive(0, 0, 0, 0, chk, disp_exp(), m_st == 1, m_lapa, 1'b0, "tick_low");
  endtask

  task automatic cmd(input logic ss, input logic cl, input logic lp, input string nm);
    if (cl) begin
      if (m_st != 1) begin
        m_st = 0; m_cs = 0; m_lap = 0; m_lapa = 1'b0;
      end
    end else if (ss) begin
      m_st = (m_st == 1) ? 2 : 1;
    end else if (lp) begin
      if (m_lapa) m_lapa = 1'b0;
      else if (m_st == 1) begin
        m_lap  = m_cs;
        m_lapa = 1'b1;
      end
    end
    drive(ss, cl, lp, 0, 1, disp_exp(), m_st == 1, m_lapa, 1'b0, nm);
  endtask

  task automatic expect_const(input logic [15:0] b, input logic r, input logic la, input logic w, input string nm);
    drive(0, 0, 0, 0, 1, b, r, la, w, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    m_st = 0; m_cs = 0; m_lap = 0; m_lapa = 1'b0;

    //            ss cl lp tk  bcd       run lapa wrap
    tbl[0]  = '{0, 0, 0, 0, 16'h0000, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 16'h0000, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 16'h0001, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 16'h0001, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 16'h0002, 0, 0, 0};  // stop + tick: counted, then paused
    tbl[5]  = '{0, 0, 0, 0, 16'h0002, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 16'h0002, 0, 0, 0};  // paused ignores tick
    tbl[7]  = '{0, 0, 0, 0, 16'h0002, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 16'h0000, 0, 0, 0};  // all commands in paused: clear wins
    tbl[9]  = '{1, 0, 0, 1, 16'h0000, 1, 0, 0};  // start + tick in idle: not counted
    tbl[10] = '{0, 0, 0, 1, 16'h0000, 1, 0, 0};  // held level, no new edge
    tbl[11] = '{0, 0, 0, 0, 16'h0000, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 16'h0000, 1, 1, 0};  // lap + tick: snapshot is pre-increment
    tbl[13] = '{0, 0, 0, 0, 16'h0000, 1, 1, 0};
    tbl[14] = '{0, 1, 0, 0, 16'h0000, 1, 1, 0};  // clear ignored in run
    tbl[15] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0};  // lap dropped under ignored clear
    tbl[16] = '{0, 0, 1, 0, 16'h0001, 1, 0, 0};  // release shows live count
    tbl[17] = '{1, 0, 0, 0, 16'h0001, 0, 0, 0};
    tbl[18] = '{0, 0, 1, 0, 16'h0001, 0, 0, 0};  // lap in paused without snapshot: ignored
    tbl[19] = '{1, 0, 0, 0, 16'h0001, 1, 0, 0};
    tbl[20] = '{0, 0, 1, 1, 16'h0001, 1, 1, 0};
    tbl[21] = '{1, 0, 0, 0, 16'h0001, 0, 1, 0};
    tbl[22] = '{1, 0, 0, 0, 16'h0001, 1, 1, 0};  // resume keeps lap_active
    tbl[23] = '{1, 0, 1, 0, 16'h0001, 0, 1, 0};  // start_stop beats lap
    tbl[24] = '{0, 0, 1, 0, 16'h0002, 0, 0, 0};  // release in paused
    tbl[25] = '{0, 1, 0, 1, 16'h0000, 0, 0, 0};  // clear + tick in paused

    do_reset(0, 0, 0);
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].ss, tbl[i].cl, tbl[i].lp, tbl[i].tk, 1'b1,
            tbl[i].bcd, tbl[i].run, tbl[i].lapa, tbl[i].wrp, $sformatf("vec%0d", i));
    end

    // 100 ticks, then on to a lap freeze at 02.50
    do_reset(0, 0, 0);
    cmd(1, 0, 0, "start");
    for (int i = 0; i < 100; i++) tick_pulse(1'b0);
    expect_const(16'h0100, 1, 0, 0, "hundred_ticks");
    for (int i = 0; i < 150; i++) tick_pulse(1'b0);
    expect_const(16'h0250, 1, 0, 0, "at_0250");
    cmd(0, 0, 1, "lap_take");
    for (int i = 0; i < 30; i++) tick_pulse(1'b1);
    expect_const(16'h0250, 1, 1, 0, "lap_frozen");
    cmd(0, 0, 1, "lap_release");
    expect_const(16'h0280, 1, 0, 0, "lap_released");

    // pause ignores ticks, clear from paused, clear ignored in run
    do_reset(0, 0, 0);
    cmd(1, 0, 0, "start");
    for (int i = 0; i < 12; i++) tick_pulse(1'b0);
    cmd(1, 0, 0, "pause");
    for (int i = 0; i < 10; i++) tick_pulse(1'b1);
    expect_const(16'h0012, 0, 0, 0, "paused_hold");
    cmd(0, 1, 0, "clear_paused");
    expect_const(16'h0000, 0, 0, 0, "cleared_idle");
    cmd(1, 0, 0, "start2");
    for (int i = 0; i < 5; i++) tick_pulse(1'b0);
    cmd(0, 1, 0, "clear_in_run");
    expect_const(16'h0005, 1, 0, 0, "clear_run_ignored");

    // rollover
    do_reset(0, 0, 0);
    cmd(1, 0, 0, "start");
    for (int i = 0; i < 5999; i++) tick_pulse(1'b0);
    expect_const(16'h5999, 1, 0, 0, "at_5999");
    drive(0, 0, 0, 1, 1, 16'h0000, 1, 0, 1, "wrap_edge");
    drive(0, 0, 0, 0, 1, 16'h0000, 1, 0, 0, "wrap_one_cycle");
    expect_const(16'h0000, 1, 0, 0, "wrap_stays_low");
    m_cs = 0;

    // reset mid-run with a snapshot held and commands asserted, then a held tick
    cmd(0, 0, 0, "idle_cycle");
    for (int i = 0; i < 3; i++) tick_pulse(1'b0);
    cmd(0, 0, 1, "lap_before_reset");
    expect_const(16'h0003, 1, 1, 0, "lap_held");
    do_reset(1, 1, 1);
    cmd(1, 0, 0, "start_after_reset");
    for (int i = 0; i < 50; i++) drive(0, 0, 0, 1, 1, 16'h0001, 1, 0, 0, "held_tick");
    expect_const(16'h0001, 1, 0, 0, "held_tick_once");

    @(posedge clk);
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
